// File: rtl/iu_mul_pkg.sv
// Shared definitions for the IU iterative multiply path: default operand
// width, Booth iteration count, FSM state encoding and Booth code width.
package iu_mul_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int BOOTH_CODE_W = 3;

    // Radix-4 Booth iterations over the (data_w+2)-bit extended multiplier.
    function automatic int iter_of(input int data_w);
        return (data_w / 2) + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/booth_code.sv
// Radix-4 Booth partial-product cell. For a 3-bit Booth code it selects
// 0, +A, +2A, -2A or -A. Negative multiples are returned as the one's
// complement in product with h=1, so the true partial product is
// sign_extend(product) + h.
module booth_code
    import iu_mul_pkg::*;
#(
    parameter int B_SIZE = 33
) (
    input  logic [B_SIZE-1:0]       a,
    input  logic [BOOTH_CODE_W-1:0] code,
    output logic [B_SIZE:0]         product,
    output logic                    h
);

    logic [B_SIZE:0] a1_s;
    logic [B_SIZE:0] a2_s;

    assign a1_s = {a[B_SIZE-1], a};
    assign a2_s = {a, 1'b0};

    // Select the multiple of A encoded by the Booth digit.
    always_comb begin
        product = '0;
        h       = 1'b0;
        case (code)
            3'b000, 3'b111: begin
                product = '0;
                h       = 1'b0;
            end
            3'b001, 3'b010: begin
                product = a1_s;
                h       = 1'b0;
            end
            3'b011: begin
                product = a2_s;
                h       = 1'b0;
            end
            3'b100: begin
                product = ~a2_s;
                h       = 1'b1;
            end
            3'b101, 3'b110: begin
                product = ~a1_s;
                h       = 1'b1;
            end
            default: begin
                product = '0;
                h       = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, the
// partial product from booth_code accumulated into a 2*DATA_W result.
// Optional macro IU_MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all equal (all further digits would be zero).
module booth_iter_mul
    import iu_mul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  cpuclk,
    input  logic                  cpurst,
    input  logic                  flush,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_W-1:0]     in_src0,
    input  logic [DATA_W-1:0]     in_src1,
    input  logic                  in_src0_signed,
    input  logic                  in_src1_signed,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [2*DATA_W-1:0]   out_result,
    output logic                  busy
);

    localparam int ITER  = iter_of(DATA_W);
    localparam int A_W   = DATA_W + 1;
    localparam int M_W   = DATA_W + 3;
    localparam int ACC_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mul_state_e              state_r;
    mul_state_e              state_nxt_s;
    logic [A_W-1:0]          a_r;
    logic [M_W-1:0]          m_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [ACC_W-1:0]        acc_r;
    logic                    out_vld_r;
    logic [2*DATA_W-1:0]     out_result_r;
    logic                    in_rdy_r;
    logic                    busy_r;

    logic [A_W:0]            product_s;
    logic                    h_s;
    logic [ACC_W-1:0]        pp_s;
    logic [ACC_W-1:0]        acc_nxt_s;
    logic [M_W-1:0]          m_shift_s;
    logic                    last_s;
    logic                    early_s;
    logic                    src0_ext_s;
    logic                    src1_ext_s;

    booth_code #(
        .B_SIZE (A_W)
    ) u_booth_code (
        .a       (a_r),
        .code    (m_r[BOOTH_CODE_W-1:0]),
        .product (product_s),
        .h       (h_s)
    );

    assign src0_ext_s = in_src0_signed & in_src0[DATA_W-1];
    assign src1_ext_s = in_src1_signed & in_src1[DATA_W-1];

    // Partial product = sign-extended cell output plus its negate carry.
    assign pp_s      = {{(ACC_W-A_W-1){product_s[A_W]}}, product_s}
                     + {{(ACC_W-1){1'b0}}, h_s};
    assign acc_nxt_s = acc_r + (pp_s << {cnt_r, 1'b0});
    // Arithmetic shift: the fill bits equal the extension bits, so they
    // never change a digit and keep the early-termination test simple.
    assign m_shift_s = {{2{m_r[M_W-1]}}, m_r[M_W-1:2]};
    assign last_s    = (cnt_r == CNT_LAST);

`ifdef IU_MUL_EARLY_TERM_EN
    assign early_s = (&m_shift_s) | ~(|m_shift_s);
`else
    assign early_s = 1'b0;
`endif

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_vld) state_nxt_s = ST_CALC;
                    else        state_nxt_s = ST_IDLE;
                end
                ST_CALC: begin
                    if (last_s || early_s) state_nxt_s = ST_DONE;
                    else                   state_nxt_s = ST_CALC;
                end
                ST_DONE: begin
                    if (out_vld_r && out_rdy) state_nxt_s = ST_IDLE;
                    else                      state_nxt_s = ST_DONE;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register with registered handshake/status outputs.
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_r  <= ST_IDLE;
            in_rdy_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            in_rdy_r <= (state_nxt_s == ST_IDLE);
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand capture, Booth accumulation and result presentation.
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            a_r          <= '0;
            m_r          <= '0;
            cnt_r        <= '0;
            acc_r        <= '0;
            out_vld_r    <= 1'b0;
            out_result_r <= '0;
        end else if (flush) begin
            cnt_r     <= '0;
            acc_r     <= '0;
            out_vld_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_vld) begin
                        a_r   <= {src0_ext_s, in_src0};
                        m_r   <= {src1_ext_s, src1_ext_s, in_src1, 1'b0};
                        cnt_r <= '0;
                        acc_r <= '0;
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_nxt_s;
                    m_r   <= m_shift_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                ST_DONE: begin
                    if (!out_vld_r) begin
                        out_vld_r    <= 1'b1;
                        out_result_r <= acc_r;
                    end else if (out_rdy) begin
                        out_vld_r <= 1'b0;
                    end
                end
                default: begin
                    out_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_rdy     = in_rdy_r;
    assign busy       = busy_r;
    assign out_vld    = out_vld_r;
    assign out_result = out_result_r;

endmodule

// File: tb/tb_booth_iter_mul.sv
// Scoreboard bench for booth_iter_mul: directed corner cases plus a
// randomized phase, checked against a plain-arithmetic reference model.
module tb_booth_iter_mul;

    localparam int W = 32;

    logic            cpuclk = 1'b0;
    logic            cpurst;
    logic            flush;
    logic            in_vld;
    logic            in_rdy;
    logic [W-1:0]    in_src0;
    logic [W-1:0]    in_src1;
    logic            in_src0_signed;
    logic            in_src1_signed;
    logic            out_vld;
    logic            out_rdy;
    logic [2*W-1:0]  out_result;
    logic            busy;

    logic [2*W-1:0]  sb_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;

    booth_iter_mul #(.DATA_W(W)) dut (
        .cpuclk         (cpuclk),
        .cpurst         (cpurst),
        .flush          (flush),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_src0        (in_src0),
        .in_src1        (in_src1),
        .in_src0_signed (in_src0_signed),
        .in_src1_signed (in_src1_signed),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_result     (out_result),
        .busy           (busy)
    );

    always #5 cpuclk = ~cpuclk;

    // Reference: full-width product of the sign/zero-extended operands.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic xs, input logic ys);
        logic [2*W-1:0] xe;
        logic [2*W-1:0] ye;
        xe = xs ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ye = ys ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    function automatic logic [W-1:0] pick_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every completed output handshake with the scoreboard;
    // a flush without a handshake discards the in-flight expectation.
    initial begin
        forever begin
            @(negedge cpuclk);
            if (!cpurst) begin
                if (out_vld && out_rdy) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: actual=%h required=none", out_result);
                    end else begin
                        check("result", out_result, sb_q.pop_front());
                    end
                end else if (flush && sb_q.size() > 0) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // Present one operation, wait (bounded) until accepted; returns #1 after the accept edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic xs, input logic ys);
        int k;
        in_src0 = x; in_src1 = y; in_src0_signed = xs; in_src1_signed = ys;
        in_vld = 1'b1;
        k = 0;
        while (!in_rdy && k < 200) begin
            @(posedge cpuclk); #1;
            k++;
        end
        if (!in_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: actual=in_rdy low required=in_rdy high");
        end
        sb_q.push_back(ref_mul(x, y, xs, ys));
        @(posedge cpuclk); #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (!out_vld && n < 100) begin
            @(posedge cpuclk); #1;
            n++;
        end
    endtask

    task automatic run_dir(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic xs, input logic ys, input logic [2*W-1:0] exp, input int lat);
        int n;
        out_rdy = 1'b1;
        issue(x, y, xs, ys);
        wait_vld(n);
        check({name, "_value"}, out_result, exp);
        if (lat >= 0) check({name, "_latency"}, 64'(n), 64'(lat));
        @(posedge cpuclk); #1;
    endtask

    initial begin
        int n;
        int seen;
        logic pending;
        logic [W-1:0] rx, ry;
        logic rxs, rys;

        cpurst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        in_src0 = '0; in_src1 = '0; in_src0_signed = 1'b0; in_src1_signed = 1'b0;
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", out_result, 64'd0);
        repeat (3) @(posedge cpuclk);
        #1 cpurst = 1'b0;

        run_dir("uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 18);
        run_dir("ss_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, -1);
        run_dir("su_m2x3", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, -1);
`ifdef IU_MUL_EARLY_TERM_EN
        run_dir("ss_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h1, 2);
`else
        run_dir("ss_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h1, 18);
`endif

        // Result held while the consumer stalls.
        out_rdy = 1'b0;
        issue(32'd7, 32'd9, 1'b0, 1'b0);
        wait_vld(n);
        repeat (5) begin
            check("hold_result", out_result, 64'd63);
            check("hold_in_rdy", 64'(in_rdy), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
            @(posedge cpuclk); #1;
        end
        out_rdy = 1'b1;
        @(posedge cpuclk); #1;
        check("release_out_vld", 64'(out_vld), 64'd0);
        check("release_in_rdy", 64'(in_rdy), 64'd1);
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        check("next_accept_busy", 64'(busy), 64'd1);
        wait_vld(n);
        check("next_value", out_result, 64'd12);
        @(posedge cpuclk); #1;

        // Flush in the middle of an operation.
        out_rdy = 1'b0;
        issue(32'd5, 32'd5, 1'b0, 1'b0);
        repeat (7) @(posedge cpuclk);
        #1 flush = 1'b1;
        @(posedge cpuclk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_rdy", 64'(in_rdy), 64'd1);
        check("flush_out_vld", 64'(out_vld), 64'd0);
        out_rdy = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge cpuclk); #1;
            if (out_vld) seen++;
        end
        check("flush_no_vld", 64'(seen), 64'd0);
        run_dir("after_flush", 32'd6, 32'd7, 1'b0, 1'b0, 64'd42, -1);

        // Flush together with in_vld in IDLE blocks the accept.
        in_vld = 1'b1; flush = 1'b1; in_src0 = 32'd2; in_src1 = 32'd2;
        @(posedge cpuclk); #1;
        in_vld = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", 64'(busy), 64'd0);

        // Asynchronous reset mid-operation.
        issue(32'd123, 32'd456, 1'b0, 1'b0);
        repeat (3) @(posedge cpuclk);
        #2 cpurst = 1'b1;
        #1;
        check("arst_out_vld", 64'(out_vld), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_rdy", 64'(in_rdy), 64'd1);
        check("arst_result", out_result, 64'd0);
        sb_q.delete();
        @(posedge cpuclk); #1;
        cpurst = 1'b0;

        // Randomized traffic with stalls and occasional flushes.
        pending = 1'b0;
        rx = '0; ry = '0; rxs = 1'b0; rys = 1'b0;
        repeat (4000) begin
            if (!pending && $urandom_range(0, 2) == 0) begin
                rx = pick_op(); ry = pick_op();
                rxs = 1'($urandom_range(0, 1)); rys = 1'($urandom_range(0, 1));
                pending = 1'b1;
            end
            in_vld = pending;
            in_src0 = rx; in_src1 = ry; in_src0_signed = rxs; in_src1_signed = rys;
            out_rdy = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            if (pending && in_rdy && !flush) begin
                sb_q.push_back(ref_mul(rx, ry, rxs, rys));
                pending = 1'b0;
            end
            @(posedge cpuclk); #1;
        end
        in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            @(posedge cpuclk); #1;
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_iter_mul.md
Name: booth_iter_mul

Overview:
- Iterative radix-4 Booth multiplier core for the IU multiply path.
- Scans the multiplier two bits per cycle and forms the 3-bit Booth code.
- Drives the existing booth_code partial-product cell and accumulates its product/h outputs into a double-width result.
- Sits between the IU issue stage (valid/ready operands) and the IU writeback mux (valid/ready result).

Parameters:
- DATA_W, 32, operand width; even, >= 4.
- ITER, DATA_W/2+1, derived (localparam); Booth iterations over the (DATA_W+2)-bit extended multiplier.

Ports:
- cpuclk  in  1  clock; all state on rising edge.
- cpurst  in  1  asynchronous, active-high reset.
- flush  in  1  kill; aborts any operation.
- in_vld  in  1  operands valid.
- in_rdy  out  1  block can accept operands.
- in_src0  in  DATA_W  multiplicand.
- in_src1  in  DATA_W  multiplier.
- in_src0_signed  in  1  src0 is two's complement.
- in_src1_signed  in  1  src1 is two's complement.
- out_vld  out  1  result valid.
- out_rdy  in  1  consumer accepts result.
- out_result  out  2*DATA_W  full product.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, cpurst=1): state=IDLE, in_rdy=1, out_vld=0, busy=0, out_result=0, iteration counter=0, accumulator=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_rdy=1.
  - Accept on in_vld&in_rdy&~flush.
  - On accept, latch the operands:
    - A = src0 extended to DATA_W+1 bits (sign or zero per in_src0_signed).
    - Multiplier register M = {ext,ext,src1,0} with ext = in_src1_signed ? src1[MSB] : 0.
  - Clear the accumulator and counter; go to CALC.
- CALC:
  - Each edge: code = M[2:0]; feed A and code to booth_code (B_SIZE=DATA_W+1).
  - pp = sign-extended product + h.
  - acc += pp << (2*cnt); M >>= 2; cnt++.
  - When cnt reaches ITER-1 on this edge, go to DONE.
  - CALC lasts exactly ITER cycles.
- DONE:
  - out_vld=1; out_result = acc[2*DATA_W-1:0], held stable until out_rdy.
  - out_vld&out_rdy -> IDLE.
  - in_rdy=0 in DONE (no bypass).
- Latency: out_vld first high ITER+1 edges after the accept edge (DATA_W=32: accept at edge 0, out_vld visible after edge 18).
- Result: exact low 2*DATA_W bits of the product of the sign/zero-extended operands, for all four signedness combinations.
- Flush: any state -> IDLE on the next edge; out_vld drops; the partial result is discarded. flush with in_vld in IDLE: no accept.
- flush and out_vld&out_rdy on the same edge: IDLE, handshake counted as completed.
- in_vld while not in_rdy: ignored; the issuer must hold the operands.
- Reset mid-operation: immediate return to reset values; no out_vld.

Optional Feature:
- IU_MUL_EARLY_TERM_EN defined:
  - In CALC, after processing a code, if all remaining unprocessed M bits (including the overlap bit) are equal, go to DONE immediately.
  - The remaining codes are 000/111, so pp=0 and the result is identical.
  - Minimum latency: 2 edges (1 CALC + DONE).
- Undefined: fixed ITER-cycle CALC; no compare logic synthesized.

Decomposition:
- Shared package iu_mul_pkg:
  - DATA_W default.
  - ITER derivation.
  - FSM state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10).
  - Booth code width constant (3).
- Sub-module: one instance of booth_code for the per-cycle partial product. Accumulator and FSM stay in booth_iter_mul.

Test Plan:
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> out_result=0xFFFFFFFE_00000001; out_vld after exactly 18 edges (feature off).
- Signed 0x80000000 x signed 0x80000000 -> 0x40000000_00000000.
- Signed 0xFFFFFFFE (-2) x unsigned 3 -> 0xFFFFFFFF_FFFFFFFA.
- Signed -1 x signed -1 -> 0x1:
  - feature on: out_vld after 2 edges;
  - feature off: out_vld after 18 edges.
- Result 7x9=63, out_rdy low 5 cycles:
  - out_result stable at 0x3F, in_rdy=0, busy=1;
  - out_rdy=1 -> IDLE next edge; new op accepted the following cycle.
- flush asserted at CALC cycle 8 of 5x5:
  - IDLE next edge, no out_vld.
  - Next op 6x7 returns 42.
  - cpurst pulse mid-CALC gives reset values asynchronously.
